// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: frame-level controller behind the WS2812 bit decoder.
// It locks onto reset gaps, assembles 24-bit GRB pixels MSB first and writes
// them into the LED pixel buffer over a valid/ready port. It also reports frame
// completion, frame length, overrun and partial-pixel errors.
// Optional feature macro: WS2812_FRAME_STATS_EN (completed-frame counter on
// o_frame_count; tied to 0 when undefined).
module ws2812_frame_ctrl #(
  parameter int MAX_PIXELS = 64,
  parameter int IDX_W      = $clog2(MAX_PIXELS)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_bit_value,
  input  logic             i_bit_valid,
  input  logic             i_treset,
  output logic [23:0]      o_pix_data,
  output logic [IDX_W-1:0] o_pix_addr,
  output logic             o_pix_valid,
  input  logic             i_pix_ready,
  output logic             o_frame_done,
  output logic [IDX_W:0]   o_frame_len,
  output logic             o_overrun,
  output logic             o_err_partial,
  input  logic             i_clear_err,
  output logic [15:0]      o_frame_count
);

  typedef enum logic [1:0] {SYNC, GAP, RECV, FULL} state_t;

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(MAX_PIXELS - 1);
  localparam logic [IDX_W:0] IDX_ONE  = (IDX_W+1)'(1);

  state_t         state_q, state_d;
  logic           r_treset_d;
  logic [23:0]    shift_q;
  logic [4:0]     bit_cnt_q;
  logic [IDX_W:0] idx_q;

  logic gap_edge, bit_acc, out_idle;
  logic clr_frame, pix_done, frame_end;
  logic pix_load, shift_en;

  // A reset gap always wins over a coincident bit strobe.
  assign gap_edge = i_treset & ~r_treset_d;
  assign bit_acc  = i_bit_valid & ~i_treset & i_enable;
  assign out_idle = ~o_pix_valid | i_pix_ready;
  assign pix_load = pix_done & out_idle;
  assign shift_en = bit_acc & ((state_q == GAP) | (state_q == RECV));

  // Gap edge detector and state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_treset_d <= 1'b0;
      state_q    <= SYNC;
    end else begin
      r_treset_d <= i_treset;
      state_q    <= state_d;
    end
  end

  // Next-state logic; entering GAP resets the per-frame bookkeeping.
  always_comb begin
    state_d   = state_q;
    clr_frame = 1'b0;
    pix_done  = 1'b0;
    frame_end = 1'b0;
    if (!i_enable) begin
      state_d = SYNC;
    end else begin
      case (state_q)
        SYNC: if (i_treset) begin
          state_d   = GAP;
          clr_frame = 1'b1;
        end
        GAP: if (bit_acc) state_d = RECV;
        RECV: begin
          if (gap_edge) begin
            frame_end = 1'b1;
            clr_frame = 1'b1;
            state_d   = GAP;
          end else if (bit_acc && bit_cnt_q == 5'd23) begin
            pix_done = 1'b1;
            if (idx_q == LAST_IDX) state_d = FULL;
          end
        end
        FULL: if (gap_edge) begin
          frame_end = 1'b1;
          clr_frame = 1'b1;
          state_d   = GAP;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // Bit assembly: shift left, count bits, advance LED index per pixel
  // (even for dropped pixels, so later LEDs keep their positions).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
    end else if (clr_frame) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[22:0], i_bit_value};
      if (pix_done) begin
        bit_cnt_q <= '0;
        idx_q     <= idx_q + IDX_ONE;
      end else begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
    end
  end

  // Output register: load when idle, hold until handshake, then clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
      o_pix_addr  <= '0;
    end else if (pix_load) begin
      o_pix_valid <= 1'b1;
      o_pix_data  <= {shift_q[22:0], i_bit_value};
      o_pix_addr  <= idx_q[IDX_W-1:0];
    end else if (o_pix_valid && i_pix_ready) begin
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
      o_pix_addr  <= '0;
    end
  end

  // Frame reporting and sticky errors; a set event beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_frame_done  <= 1'b0;
      o_frame_len   <= '0;
      o_overrun     <= 1'b0;
      o_err_partial <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      if (frame_end) o_frame_len <= idx_q;
      if (pix_done && !out_idle) o_overrun <= 1'b1;
      else if (i_clear_err)      o_overrun <= 1'b0;
      if (frame_end && bit_cnt_q != 5'd0) o_err_partial <= 1'b1;
      else if (i_clear_err)               o_err_partial <= 1'b0;
    end
  end

`ifdef WS2812_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;

  // Saturating completed-frame counter, aligned with o_frame_done.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                             frame_cnt_q <= '0;
    else if (frame_end && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign o_frame_count = frame_cnt_q;
`else
  assign o_frame_count = 16'h0;
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl, built with MAX_PIXELS=4 so the
// frame-full path is reachable with short frames.
module tb_ws2812_frame_ctrl;
  localparam int MAXP = 4;
  localparam int IW   = $clog2(MAXP);

  logic          i_clk = 1'b0;
  logic          i_reset_n, i_enable, i_bit_value, i_bit_valid, i_treset;
  logic          i_pix_ready, i_clear_err;
  logic [23:0]   o_pix_data;
  logic [IW-1:0] o_pix_addr;
  logic          o_pix_valid, o_frame_done, o_overrun, o_err_partial;
  logic [IW:0]   o_frame_len;
  logic [15:0]   o_frame_count;

  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [23:0] wd[$];
  int          wa[$];

  ws2812_frame_ctrl #(.MAX_PIXELS(MAXP)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_bit_value(i_bit_value), .i_bit_valid(i_bit_valid), .i_treset(i_treset),
    .o_pix_data(o_pix_data), .o_pix_addr(o_pix_addr), .o_pix_valid(o_pix_valid),
    .i_pix_ready(i_pix_ready), .o_frame_done(o_frame_done),
    .o_frame_len(o_frame_len), .o_overrun(o_overrun),
    .o_err_partial(o_err_partial), .i_clear_err(i_clear_err),
    .o_frame_count(o_frame_count)
  );

  always #5 i_clk = ~i_clk;

  // Record every buffer write (valid & ready at a clock edge).
  always @(posedge i_clk)
    if (i_reset_n && o_pix_valid && i_pix_ready) begin
      wd.push_back(o_pix_data);
      wa.push_back(int'(o_pix_addr));
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // n bits from d MSB first, one idle cycle before each strobe; returns just
  // after the edge that samples the last strobe.
  task automatic send_bits(input logic [23:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      i_bit_valid = 1'b0;
      tick();
      i_bit_valid = 1'b1;
      i_bit_value = d[23-i];
      tick();
    end
    i_bit_valid = 1'b0;
  endtask

  // Full pixel, checking the write appears one cycle after the 24th strobe.
  task automatic send_pixel(input string tag, input logic [23:0] d, input int addr);
    send_bits(d, 24);
    check({tag, "_valid"}, 32'(o_pix_valid), 32'd1);
    check({tag, "_data"}, 32'(o_pix_data), 32'(d));
    check({tag, "_addr"}, 32'(o_pix_addr), 32'(addr));
  endtask

  task automatic gap(input string tag, input logic exp_done, input int exp_len);
    i_treset = 1'b1;
    tick();
    check({tag, "_done"}, 32'(o_frame_done), 32'(exp_done));
    if (exp_done) begin
      frames++;
      check({tag, "_len"}, 32'(o_frame_len), 32'(exp_len));
    end
    tick();
    check({tag, "_done_pulse"}, 32'(o_frame_done), 32'd0);
    tick();
    i_treset = 1'b0;
    tick();
  endtask

  task automatic chk_frame_count(input string tag);
`ifdef WS2812_FRAME_STATS_EN
    check(tag, 32'(o_frame_count), 32'(frames));
`else
    check(tag, 32'(o_frame_count), 32'd0);
`endif
  endtask

  initial begin
    i_reset_n = 1'b0; i_enable = 1'b1; i_bit_value = 1'b0; i_bit_valid = 1'b0;
    i_treset = 1'b0; i_pix_ready = 1'b1; i_clear_err = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(o_pix_valid), 32'd0);
    check("rst_data", 32'(o_pix_data), 32'd0);
    check("rst_done", 32'(o_frame_done), 32'd0);
    check("rst_len", 32'(o_frame_len), 32'd0);
    check("rst_flags", {30'd0, o_overrun, o_err_partial}, 32'd0);
    check("rst_fcnt", 32'(o_frame_count), 32'd0);
    i_reset_n = 1'b1;
    tick();

    // Bits before the first gap are ignored.
    send_bits(24'h123456, 24);
    tick();
    check("nosync_writes", 32'(wd.size()), 32'd0);
    gap("sync_gap", 1'b0, 0);

    // Basic two-pixel frame.
    send_pixel("p0", 24'h00FF00, 0);
    send_pixel("p1", 24'hA5C3E1, 1);
    gap("f1", 1'b1, 2);
    check("f1_writes", 32'(wd.size()), 32'd2);
    check("f1_w1", 32'(wd[1]), 32'h00A5C3E1);
    check("f1_a1", 32'(wa[1]), 32'd1);
    check("f1_flags", {30'd0, o_overrun, o_err_partial}, 32'd0);
    chk_frame_count("f1_fcnt");
    wd.delete(); wa.delete();

    // Backpressure: second pixel dropped, first held stable.
    i_pix_ready = 1'b0;
    send_pixel("bp0", 24'h102030, 0);
    send_bits(24'h405060, 24);
    check("bp_hold_data", 32'(o_pix_data), 32'h00102030);
    check("bp_hold_addr", 32'(o_pix_addr), 32'd0);
    check("bp_overrun", 32'(o_overrun), 32'd1);
    gap("bp", 1'b1, 2);
    check("bp_still_valid", 32'(o_pix_valid), 32'd1);
    i_pix_ready = 1'b1;
    tick();
    check("bp_cleared", 32'(o_pix_valid), 32'd0);
    send_pixel("bp_next", 24'h0A0B0C, 0);
    gap("bp2", 1'b1, 1);
    check("bp_writes", 32'(wd.size()), 32'd2);
    check("bp_w0", 32'(wd[0]), 32'h00102030);
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    check("bp_ovr_clr", 32'(o_overrun), 32'd0);
    wd.delete(); wa.delete();

    // 30 bits: one pixel plus a partial one.
    send_pixel("part", 24'h112233, 0);
    send_bits(24'hFC0000, 6);
    gap("part", 1'b1, 1);
    check("part_err", 32'(o_err_partial), 32'd1);
    check("part_writes", 32'(wd.size()), 32'd1);
    i_clear_err = 1'b1;
    tick();
    i_clear_err = 1'b0;
    check("part_clr", 32'(o_err_partial), 32'd0);
    wd.delete(); wa.delete();

    // Six pixels into a four-LED buffer.
    for (int k = 0; k < 4; k++) send_pixel("full", 24'h010101 * (k + 1), k);
    send_bits(24'hEEEEEE, 24);
    send_bits(24'hDDDDDD, 24);
    tick();
    check("full_writes", 32'(wd.size()), 32'd4);
    check("full_a3", 32'(wa[3]), 32'd3);
    check("full_w3", 32'(wd[3]), 32'h00040404);
    check("full_ovr", 32'(o_overrun), 32'd0);
    gap("full", 1'b1, 4);
    chk_frame_count("full_fcnt");
    wd.delete(); wa.delete();

    // Disable mid-pixel: partial discarded silently, no frame end.
    send_bits(24'hFFFFFF, 10);
    i_enable = 1'b0;
    tick();
    i_enable = 1'b1;
    gap("dis", 1'b0, 0);
    check("dis_err", 32'(o_err_partial), 32'd0);
    check("dis_writes", 32'(wd.size()), 32'd0);

    // Async reset mid-pixel, then a fresh frame.
    send_bits(24'hFFFFFF, 10);
    i_reset_n = 1'b0;
    #2;
    frames = 0;
    check("arst_len", 32'(o_frame_len), 32'd0);
    check("arst_valid", 32'(o_pix_valid), 32'd0);
    check("arst_fcnt", 32'(o_frame_count), 32'd0);
    tick();
    i_reset_n = 1'b1;
    tick();
    gap("arst_gap", 1'b0, 0);
    send_pixel("arst", 24'hC0FFEE, 0);
    gap("arst", 1'b1, 1);
    chk_frame_count("arst_fcnt2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
